// File: rtl/config_loader.sv
// Configuration chain loader.
// Takes bitstream bytes over a valid/ready port and shifts them, MSB first,
// into a serial configuration chain using a generated prog_clk. prog_en is
// held high for the whole load and its falling edge commits the chain.
// Bytes are pulled only as the shifter needs them, so bits past CHAIN_LEN in
// the final byte are dropped without producing extra prog_clk edges.
module config_loader #(
  parameter int CHAIN_LEN = 76,
  parameter int DIV       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       prog_in,
  output logic       prog_clk,
  output logic       prog_en,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  // Handshake: a byte moves on a rising clk edge where data_valid and
  // data_ready are both 1. data_ready is registered and is 1 only in FETCH;
  // the source may hold data_valid low for any number of cycles, and a byte
  // offered while data_ready is 0 is neither consumed nor lost.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_HIGH   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  state_t          r_state;
  logic [7:0]      r_byte;
  logic [CW-1:0]   r_bit_cnt;
  logic [3:0]      r_byte_cnt;
  logic [DW-1:0]   r_div_cnt;
  logic            r_prog_in;
  logic            r_prog_clk;
  logic            r_prog_en;
  logic            r_data_ready;
  logic            r_busy;
  logic            r_done;

  logic            w_div_last;
  logic [CW-1:0]   w_bit_cnt_nxt;
  logic [3:0]      w_byte_cnt_nxt;
  logic            w_chain_end;

  // Phase timing and counter look-ahead used at the end of each HIGH phase.
  assign w_div_last     = (r_div_cnt == DW'(DIV - 1));
  assign w_bit_cnt_nxt  = r_bit_cnt + CW'(1);
  assign w_byte_cnt_nxt = r_byte_cnt - 4'd1;
  assign w_chain_end    = (w_bit_cnt_nxt == CW'(CHAIN_LEN));

  // Load sequencer: state plus every output is registered here; outputs are
  // updated on the edge that enters the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_byte       <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_div_cnt    <= '0;
      r_prog_in    <= 1'b0;
      r_prog_clk   <= 1'b0;
      r_prog_en    <= 1'b0;
      r_data_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_FETCH;
            r_done       <= 1'b0;
            r_bit_cnt    <= '0;
            r_busy       <= 1'b1;
            r_prog_en    <= 1'b1;
            r_data_ready <= 1'b1;
            r_prog_clk   <= 1'b0;
          end
        end
        S_FETCH: begin
          if (data_valid && r_data_ready) begin
            r_byte       <= data_in;
            r_byte_cnt   <= 4'd8;
            r_prog_in    <= data_in[7];
            r_data_ready <= 1'b0;
            r_div_cnt    <= '0;
            r_state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_div_last) begin
            r_div_cnt  <= '0;
            r_prog_clk <= 1'b1;
            r_state    <= S_HIGH;
          end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
          end
        end
        S_HIGH: begin
          if (w_div_last) begin
            r_div_cnt  <= '0;
            r_prog_clk <= 1'b0;
            r_byte     <= {r_byte[6:0], 1'b0};
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            if (w_chain_end) begin
              r_prog_en <= 1'b0;
              r_state   <= S_COMMIT;
            end else if (w_byte_cnt_nxt == 4'd0) begin
              r_data_ready <= 1'b1;
              r_state      <= S_FETCH;
            end else begin
              // next bit changes together with the prog_clk fall
              r_prog_in <= r_byte[6];
              r_state   <= S_SETUP;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
          end
        end
        S_COMMIT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state      <= S_IDLE;
          r_prog_clk   <= 1'b0;
          r_prog_en    <= 1'b0;
          r_data_ready <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = r_data_ready;
  assign prog_in    = r_prog_in;
  assign prog_clk   = r_prog_clk;
  assign prog_en    = r_prog_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: DUT a (CHAIN_LEN=19, DIV=1) and DUT b
// (CHAIN_LEN=76, DIV=3) share stimulus; sel picks the active one.
module tb_config_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       poke_start;
  logic [7:0] data_in;
  logic       data_valid;
  logic       sel;

  logic       a_start, a_data_ready, a_prog_in, a_prog_clk, a_prog_en, a_busy, a_done;
  logic       b_start, b_data_ready, b_prog_in, b_prog_clk, b_prog_en, b_busy, b_done;
  logic [2:0] a_dbg, b_dbg;

  logic       m_data_ready, m_prog_in, m_prog_clk, m_prog_en, m_busy, m_done;
  int         m_div, m_len;

  int         n_checks = 0;
  int         n_err    = 0;

  logic [7:0] byte_q[$];
  int         stall_q[$];
  logic [0:0] exp_q[$];
  logic [0:0] cap_q[$];

  // monitor state
  logic       prev_clk, prev_in, prev_en, expect_done;
  int         stable, low_run, high_run, rise_idx;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          stall;
    logic [18:0] bits;
  } vec_t;
  vec_t vecs[4];

  assign a_start = (start | poke_start) & ~sel;
  assign b_start = (start | poke_start) & sel;

  config_loader #(.CHAIN_LEN(19), .DIV(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .data_in(data_in), .data_valid(data_valid),
    .data_ready(a_data_ready), .prog_in(a_prog_in), .prog_clk(a_prog_clk),
    .prog_en(a_prog_en), .busy(a_busy), .done(a_done), .dbg_state(a_dbg)
  );

  config_loader #(.CHAIN_LEN(76), .DIV(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .data_in(data_in), .data_valid(data_valid),
    .data_ready(b_data_ready), .prog_in(b_prog_in), .prog_clk(b_prog_clk),
    .prog_en(b_prog_en), .busy(b_busy), .done(b_done), .dbg_state(b_dbg)
  );

  assign m_data_ready = sel ? b_data_ready : a_data_ready;
  assign m_prog_in    = sel ? b_prog_in    : a_prog_in;
  assign m_prog_clk   = sel ? b_prog_clk   : a_prog_clk;
  assign m_prog_en    = sel ? b_prog_en    : a_prog_en;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_done       = sel ? b_done       : a_done;
  assign m_div        = sel ? 3  : 1;
  assign m_len        = sel ? 76 : 19;

  // clock / reset-free clock generator
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min);
    n_checks++;
    if (act < min) begin
      n_err++;
      $display("FAIL %s: got %0d expected at least %0d at %0t", name, act, min, $time);
    end
  endtask

  // Reference model: the chain receives the first len bits of the byte
  // stream, each byte MSB first.
  task automatic model_fill(input int len);
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      b = byte_q[i / 8];
      exp_q.push_back(b[7 - (i % 8)]);
    end
  endtask

  // Monitor: samples on the falling clk edge, captures prog_in at each
  // prog_clk rise and checks phase timing and commit behaviour.
  initial begin
    prev_clk = 0; prev_in = 0; prev_en = 0; expect_done = 0;
    stable = 0; low_run = 0; high_run = 0; rise_idx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_clk = 0; prev_in = 0; prev_en = 0; expect_done = 0;
        stable = 0; low_run = 0; high_run = 0; rise_idx = 0;
      end else begin
        if (expect_done) begin
          chk("done_after_commit", {30'd0, m_done, m_busy}, 32'h2);
          expect_done = 0;
        end
        chk("clk_only_with_en", {31'd0, m_prog_clk & ~m_prog_en}, 32'd0);
        if (m_prog_en && !prev_en) rise_idx = 0;
        stable = (m_prog_in != prev_in) ? 1 : stable + 1;
        if (m_prog_clk && !prev_clk) begin
          chk_ge("prog_in_setup", stable, m_div + 1);
          if (rise_idx % 8 != 0) chk("low_phase", low_run, m_div);
          else chk_ge("low_phase_fetch", low_run, m_div);
          cap_q.push_back(m_prog_in);
          rise_idx++;
        end
        if (m_prog_clk && prev_clk) chk("prog_in_hold", {31'd0, m_prog_in}, {31'd0, prev_in});
        if (!m_prog_clk && prev_clk) chk("high_phase", high_run, m_div);
        if (!m_prog_en && prev_en) begin
          chk("commit_edge_count", rise_idx, m_len);
          chk("commit_after_high", {31'd0, prev_clk}, 32'd1);
          chk("commit_flags", {30'd0, m_done, m_busy}, 32'h1);
          expect_done = 1;
        end
        if (m_prog_clk) begin
          high_run = prev_clk ? high_run + 1 : 1;
          low_run  = 0;
        end else begin
          low_run  = prev_clk ? 1 : low_run + 1;
          high_run = 0;
        end
        prev_clk = m_prog_clk;
        prev_in  = m_prog_in;
        prev_en  = m_prog_en;
      end
    end
  end

  // Driver: one full load of byte_q with per-byte stalls from stall_q,
  // then scoreboard the captured bits against exp_q.
  task automatic do_load();
    int waited;
    cap_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_clears_done", {31'd0, m_done}, 32'd0);
    chk("busy_after_start", {31'd0, m_busy}, 32'd1);
    chk("en_after_start", {31'd0, m_prog_en}, 32'd1);
    for (int k = 0; k < byte_q.size(); k++) begin
      waited = 0;
      while (!m_data_ready && waited < 2000) begin @(negedge clk); waited++; end
      chk("ready_wait", {31'd0, m_data_ready}, 32'd1);
      for (int s = 0; s < stall_q[k]; s++) begin
        chk("stall_en_clk", {30'd0, m_prog_en, m_prog_clk}, 32'h2);
        @(negedge clk);
      end
      data_in = byte_q[k]; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      chk("ready_drop", {31'd0, m_data_ready}, 32'd0);
    end
    waited = 0;
    while (!m_done && waited < 2000) begin @(negedge clk); waited++; end
    chk("done_set", {31'd0, m_done}, 32'd1);
    chk("busy_clear", {31'd0, m_busy}, 32'd0);
    chk("en_clear", {31'd0, m_prog_en}, 32'd0);
    chk("edge_count", cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("bit%0d", i), {31'd0, cap_q[i]}, {31'd0, exp_q[i]});
  endtask

  task automatic load_vec(input vec_t v);
    logic [18:0] bits;
    byte_q.delete(); stall_q.delete(); exp_q.delete();
    byte_q.push_back(v.b0); byte_q.push_back(v.b1); byte_q.push_back(v.b2);
    stall_q.push_back(0); stall_q.push_back(v.stall); stall_q.push_back(0);
    bits = v.bits;
    for (int i = 18; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  task automatic rand_load(input int len);
    byte_q.delete(); stall_q.delete();
    for (int k = 0; k < (len + 7) / 8; k++) begin
      byte_q.push_back(8'($urandom_range(0, 255)));
      stall_q.push_back($urandom_range(0, 4));
    end
    model_fill(len);
    do_load();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_prog_en"},    {31'd0, m_prog_en},    32'd0);
    chk({name, "_prog_clk"},   {31'd0, m_prog_clk},   32'd0);
    chk({name, "_data_ready"}, {31'd0, m_data_ready}, 32'd0);
    chk({name, "_busy"},       {31'd0, m_busy},       32'd0);
    chk({name, "_done"},       {31'd0, m_done},       32'd0);
    chk({name, "_prog_in"},    {31'd0, m_prog_in},    32'd0);
  endtask

  int pw;

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 8'hE0, 0,  19'b1010010100111100111};
    vecs[1] = '{8'hA5, 8'h3C, 8'hE0, 10, 19'b1010010100111100111};
    vecs[2] = '{8'hFF, 8'h00, 8'h20, 2,  19'b1111111100000000001};
    vecs[3] = '{8'h00, 8'h01, 8'hC0, 1,  19'b0000000000000001110};

    sel = 1'b0; start = 1'b0; poke_start = 1'b0; data_in = 8'h00; data_valid = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk_all_zero("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // table-driven loads, including the reference stream and backpressure
    for (int i = 0; i < 4; i++) begin
      load_vec(vecs[i]);
      do_load();
    end

    // start pulsed while shifting is ignored
    load_vec(vecs[0]);
    fork
      do_load();
      begin
        pw = 0;
        while (!(rise_idx >= 3 && m_prog_en && !m_prog_clk && !m_data_ready) && pw < 500) begin
          @(negedge clk); pw++;
        end
        poke_start = 1'b1;
        @(negedge clk);
        poke_start = 1'b0;
      end
    join

    // mid-cycle reset while idle with done set
    chk("done_before_rst", {31'd0, m_done}, 32'd1);
    @(posedge clk); #4 rst = 1'b1;
    #1 chk_all_zero("rst_idle");
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // reset after 7 bits aborts the load
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; data_in = 8'h5A; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    pw = 0;
    while (rise_idx < 7 && pw < 200) begin @(negedge clk); pw++; end
    chk_ge("reach_bit7", rise_idx, 7);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk_all_zero("rst_load");
    @(negedge clk); @(negedge clk); rst = 1'b0;
    load_vec(vecs[2]);
    do_load();

    // randomized loads on both configurations
    for (int i = 0; i < 6; i++) rand_load(19);
    @(negedge clk); sel = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rand_load(76);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
